// File: rtl/lcd_cfg_sequencer_pkg.sv
// Shared encodings for the LCD configuration sequencer:
// table entry layout, op codes and FSM state constants.
package lcd_cfg_sequencer_pkg;

    localparam int ENTRY_W = 17;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'd0,
        OP_VERIFY = 2'd1,
        OP_DELAY  = 2'd2,
        OP_END    = 2'd3
    } op_e;

    typedef struct packed {
        op_e        op;
        logic [6:0] addr;
        logic [7:0] data;
    } entry_t;

    localparam logic [3:0] ST_PWRUP      = 4'd0;
    localparam logic [3:0] ST_FETCH      = 4'd1;
    localparam logic [3:0] ST_ISSUE      = 4'd2;
    localparam logic [3:0] ST_WAIT       = 4'd3;
    localparam logic [3:0] ST_CHECK      = 4'd4;
    localparam logic [3:0] ST_DELAY      = 4'd5;
    localparam logic [3:0] ST_IDLE       = 4'd6;
    localparam logic [3:0] ST_HOST_ISSUE = 4'd7;
    localparam logic [3:0] ST_HOST_WAIT  = 4'd8;
    localparam logic [3:0] ST_ERROR      = 4'd9;

endpackage

// File: rtl/lcd_cfg_rom.sv
// Init table for the LCD panel; registered read, one cycle latency.
// Addresses at or beyond TABLE_DEPTH read back as END.
module lcd_cfg_rom
    import lcd_cfg_sequencer_pkg::*;
#(
    parameter int TABLE_DEPTH = 32,
    parameter int AW          = 6
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic [AW-1:0] i_addr,
    output entry_t        o_entry
);

    entry_t entry_d;
    logic [ENTRY_W-1:0] entry_q;

    always_comb begin
        entry_d = '{OP_END, 7'h00, 8'h00};
        if (int'(i_addr) < TABLE_DEPTH) begin
            case (i_addr)
                AW'(0):  entry_d = '{OP_WRITE,  7'h08, 8'h36};
                AW'(1):  entry_d = '{OP_VERIFY, 7'h08, 8'h36};
                AW'(2):  entry_d = '{OP_WRITE,  7'h09, 8'h11};
                AW'(3):  entry_d = '{OP_DELAY,  7'h00, 8'h03};
                AW'(4):  entry_d = '{OP_WRITE,  7'h0A, 8'h22};
                AW'(5):  entry_d = '{OP_DELAY,  7'h00, 8'h00};
                AW'(6):  entry_d = '{OP_WRITE,  7'h0B, 8'h33};
                default: entry_d = '{OP_END,    7'h00, 8'h00};
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) entry_q <= '0;
        else         entry_q <= entry_d;
    end

    assign o_entry = entry_t'(entry_q);

endmodule

// File: rtl/lcd_cfg_sequencer.sv
// Walks the LCD init table over SPI (write / read-verify / delay),
// then serves host register accesses from IDLE or ERROR.
module lcd_cfg_sequencer
    import lcd_cfg_sequencer_pkg::*;
#(
    parameter int TABLE_DEPTH    = 32,
    parameter int DELAY_UNIT     = 1000,
    parameter int POWERUP_CYCLES = 50000,
    parameter int MAX_RETRY      = 3,
    parameter int SPI_TIMEOUT    = 4096
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_restart,
    output logic       o_spiTxBegin,
    output logic [6:0] o_spiTxAddress,
    output logic [7:0] o_spiTxData,
    input  logic       i_spiTxBusy,
    input  logic       i_spiTxDone,
    output logic       o_spiRxBegin,
    output logic [6:0] o_spiRxAddress,
    input  logic [7:0] i_spiRxData,
    input  logic       i_spiRxBusy,
    input  logic       i_spiRxDone,
    input  logic       i_hostReq,
    input  logic       i_hostWrite,
    input  logic [6:0] i_hostAddress,
    input  logic [7:0] i_hostData,
    output logic       o_hostAck,
    output logic [7:0] o_hostRxData,
    output logic       o_hostError,
    output logic       o_initDone,
    output logic       o_initError
);

    localparam int IW = $clog2(TABLE_DEPTH + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [IW-1:0] IDX_END   = IW'(TABLE_DEPTH);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [31:0] PWR_LAST  = 32'(POWERUP_CYCLES > 0 ? POWERUP_CYCLES - 1 : 0);
    localparam logic [31:0] UNIT_LAST = 32'(DELAY_UNIT > 0 ? DELAY_UNIT - 1 : 0);
    localparam logic [31:0] TMO_LAST  = 32'(SPI_TIMEOUT > 0 ? SPI_TIMEOUT - 1 : 0);

    logic [3:0]    state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [14:0]   dly_q, dly_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [7:0]    rxbuf_q, rxbuf_d;
    logic          h_wr_q, h_wr_d;
    logic [6:0]    h_addr_q, h_addr_d;
    logic [7:0]    h_data_q, h_data_d;
    logic          tx_begin_q, tx_begin_d;
    logic          rx_begin_q, rx_begin_d;
    logic [6:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          ack_q, ack_d;
    logic [7:0]    hrx_q, hrx_d;
    logic          herr_q, herr_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    entry_t ent;
    logic   spi_idle;
    logic [3:0] home_st;

    // ROM is addressed with the next index so ent always matches idx_q.
    lcd_cfg_rom #(
        .TABLE_DEPTH (TABLE_DEPTH),
        .AW          (IW)
    ) u_rom (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_addr  (idx_d),
        .o_entry (ent)
    );

    assign spi_idle = !i_spiTxBusy && !i_spiRxBusy;
    assign home_st  = err_q ? ST_ERROR : ST_IDLE;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dly_d      = dly_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        rxbuf_d    = rxbuf_q;
        h_wr_d     = h_wr_q;
        h_addr_d   = h_addr_q;
        h_data_d   = h_data_q;
        tx_begin_d = 1'b0;
        rx_begin_d = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        ack_d      = 1'b0;
        hrx_d      = hrx_q;
        herr_d     = 1'b0;
        done_d     = done_q;
        err_d      = err_q;
        unique case (state_q)
            ST_PWRUP: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q >= PWR_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (idx_q == IDX_END || ent.op == OP_END) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (ent.op == OP_DELAY) begin
                    cnt_d   = '0;
                    dly_d   = '0;
                    state_d = ST_DELAY;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (spi_idle) begin
                    tx_begin_d = (ent.op == OP_WRITE);
                    rx_begin_d = (ent.op == OP_VERIFY);
                    addr_d     = ent.addr;
                    data_d     = ent.data;
                    cnt_d      = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (i_spiTxDone) begin
                    idx_d   = idx_q + IW'(1);
                    retry_d = '0;
                    state_d = ST_FETCH;
                end else if (i_spiRxDone) begin
                    rxbuf_d = i_spiRxData;
                    state_d = ST_CHECK;
                end else if (cnt_q >= TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_ERROR;
                end
            end
            ST_CHECK: begin
                if (rxbuf_q == ent.data) begin
                    idx_d   = idx_q + IW'(1);
                    retry_d = '0;
                    state_d = ST_FETCH;
                end else if (retry_q == RETRY_MAX) begin
                    err_d   = 1'b1;
                    state_d = ST_ERROR;
                end else begin
                    retry_d = retry_q + RW'(1);
                    state_d = ST_ISSUE;
                end
            end
            ST_DELAY: begin
                if (dly_q == {ent.addr, ent.data}) begin
                    idx_d   = idx_q + IW'(1);
                    retry_d = '0;
                    state_d = ST_FETCH;
                end else if (cnt_q >= UNIT_LAST) begin
                    cnt_d = '0;
                    dly_d = dly_q + 15'd1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_IDLE, ST_ERROR: begin
                // ack_q gate keeps a still-held request from re-issuing.
                if (i_restart) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    retry_d = '0;
                    state_d = ST_FETCH;
                end else if (i_hostReq && !ack_q) begin
                    h_wr_d   = i_hostWrite;
                    h_addr_d = i_hostAddress;
                    h_data_d = i_hostData;
                    state_d  = ST_HOST_ISSUE;
                end
            end
            ST_HOST_ISSUE: begin
                if (spi_idle) begin
                    tx_begin_d = h_wr_q;
                    rx_begin_d = !h_wr_q;
                    addr_d     = h_addr_q;
                    data_d     = h_data_q;
                    cnt_d      = '0;
                    state_d    = ST_HOST_WAIT;
                end
            end
            ST_HOST_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (i_spiTxDone || i_spiRxDone) begin
                    ack_d   = 1'b1;
                    hrx_d   = h_wr_q ? hrx_q : i_spiRxData;
                    state_d = home_st;
                end else if (cnt_q >= TMO_LAST) begin
                    ack_d   = 1'b1;
                    herr_d  = 1'b1;
                    state_d = home_st;
                end
            end
            default: state_d = ST_PWRUP;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_PWRUP;
            cnt_q      <= '0;
            dly_q      <= '0;
            idx_q      <= '0;
            retry_q    <= '0;
            rxbuf_q    <= '0;
            h_wr_q     <= 1'b0;
            h_addr_q   <= '0;
            h_data_q   <= '0;
            tx_begin_q <= 1'b0;
            rx_begin_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            ack_q      <= 1'b0;
            hrx_q      <= '0;
            herr_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dly_q      <= dly_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            rxbuf_q    <= rxbuf_d;
            h_wr_q     <= h_wr_d;
            h_addr_q   <= h_addr_d;
            h_data_q   <= h_data_d;
            tx_begin_q <= tx_begin_d;
            rx_begin_q <= rx_begin_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            hrx_q      <= hrx_d;
            herr_q     <= herr_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign o_spiTxBegin   = tx_begin_q;
    assign o_spiTxAddress = addr_q;
    assign o_spiTxData    = data_q;
    assign o_spiRxBegin   = rx_begin_q;
    assign o_spiRxAddress = addr_q;
    assign o_hostAck      = ack_q;
    assign o_hostRxData   = hrx_q;
    assign o_hostError    = herr_q;
    assign o_initDone     = done_q;
    assign o_initError    = err_q;

endmodule

// File: tb/tb_lcd_cfg_sequencer.sv
// Bench for lcd_cfg_sequencer: SPI slave model with register memory,
// reference table walk and memory model for host accesses.
module tb_lcd_cfg_sequencer;

    localparam int TD = 16;
    localparam int DU = 10;
    localparam int PU = 20;
    localparam int MR = 3;
    localparam int TO = 64;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_restart = 1'b0;
    logic       o_spiTxBegin;
    logic [6:0] o_spiTxAddress;
    logic [7:0] o_spiTxData;
    logic       i_spiTxBusy = 1'b0;
    logic       i_spiTxDone = 1'b0;
    logic       o_spiRxBegin;
    logic [6:0] o_spiRxAddress;
    logic [7:0] i_spiRxData = 8'h00;
    logic       i_spiRxBusy = 1'b0;
    logic       i_spiRxDone = 1'b0;
    logic       i_hostReq = 1'b0;
    logic       i_hostWrite = 1'b0;
    logic [6:0] i_hostAddress = 7'h00;
    logic [7:0] i_hostData = 8'h00;
    logic       o_hostAck;
    logic [7:0] o_hostRxData;
    logic       o_hostError;
    logic       o_initDone;
    logic       o_initError;
    logic [35:0] outs;

    lcd_cfg_sequencer #(
        .TABLE_DEPTH    (TD),
        .DELAY_UNIT     (DU),
        .POWERUP_CYCLES (PU),
        .MAX_RETRY      (MR),
        .SPI_TIMEOUT    (TO)
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_restart      (i_restart),
        .o_spiTxBegin   (o_spiTxBegin),
        .o_spiTxAddress (o_spiTxAddress),
        .o_spiTxData    (o_spiTxData),
        .i_spiTxBusy    (i_spiTxBusy),
        .i_spiTxDone    (i_spiTxDone),
        .o_spiRxBegin   (o_spiRxBegin),
        .o_spiRxAddress (o_spiRxAddress),
        .i_spiRxData    (i_spiRxData),
        .i_spiRxBusy    (i_spiRxBusy),
        .i_spiRxDone    (i_spiRxDone),
        .i_hostReq      (i_hostReq),
        .i_hostWrite    (i_hostWrite),
        .i_hostAddress  (i_hostAddress),
        .i_hostData     (i_hostData),
        .o_hostAck      (o_hostAck),
        .o_hostRxData   (o_hostRxData),
        .o_hostError    (o_hostError),
        .o_initDone     (o_initDone),
        .o_initError    (o_initError)
    );

    assign outs = {o_spiTxBegin, o_spiTxAddress, o_spiTxData,
                   o_spiRxBegin, o_spiRxAddress, o_hostAck,
                   o_hostRxData, o_hostError, o_initDone, o_initError};

    always #5 i_clock = ~i_clock;

    typedef struct {
        bit         rx;
        logic [6:0] a;
        logic [7:0] d;
        int         t;
    } ev_t;

    ev_t  log_q[$];
    ev_t  exp_q[$];
    ev_t  ev;
    logic [7:0] dev_mem [128];
    logic [7:0] ref_mem [128];

    // Table contents the panel is expected to receive: op 0 W, 1 V, 2 D, 3 END
    int t_op [8] = '{0, 1, 0, 2, 0, 2, 0, 3};
    int t_a  [8] = '{8'h08, 8'h08, 8'h09, 8'h00, 8'h0A, 8'h00, 8'h0B, 8'h00};
    int t_d  [8] = '{8'h36, 8'h36, 8'h11, 8'h03, 8'h22, 8'h00, 8'h33, 8'h00};

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int viol = 0;
    int mode = 0;
    int lat_min = 1;
    int lat_max = 4;
    int lat_cnt = 0;
    bit pend = 0;
    bit pend_rx = 0;
    logic [6:0] pend_a;
    logic [7:0] pend_d;
    bit tx_prev = 0;
    bit rx_prev = 0;

    // SPI slave: mode 0 echoes memory, 1 reads zero, 2 never completes
    always @(posedge i_clock) begin
        #1;
        cyc = cyc + 1;
        i_spiTxDone = 1'b0;
        i_spiRxDone = 1'b0;
        if (i_reset) begin
            pend = 0;
            i_spiTxBusy = 1'b0;
            i_spiRxBusy = 1'b0;
            tx_prev = 0;
            rx_prev = 0;
        end else begin
            if (pend) begin
                lat_cnt = lat_cnt - 1;
                if (lat_cnt <= 0) begin
                    pend = 0;
                    if (pend_rx) begin
                        i_spiRxDone = 1'b1;
                        i_spiRxBusy = 1'b0;
                        i_spiRxData = (mode == 1) ? 8'h00 : dev_mem[pend_a];
                    end else begin
                        i_spiTxDone = 1'b1;
                        i_spiTxBusy = 1'b0;
                        dev_mem[pend_a] = pend_d;
                    end
                end
            end
            if (o_spiTxBegin || o_spiRxBegin) begin
                if (o_spiTxBegin && o_spiRxBegin) viol++;
                if (pend) viol++;
                if ((o_spiTxBegin && tx_prev) || (o_spiRxBegin && rx_prev)) viol++;
                ev.rx = o_spiRxBegin;
                ev.a  = o_spiRxBegin ? o_spiRxAddress : o_spiTxAddress;
                ev.d  = o_spiTxData;
                ev.t  = cyc;
                log_q.push_back(ev);
                if (mode != 2) begin
                    pend    = 1;
                    pend_rx = o_spiRxBegin;
                    pend_a  = ev.a;
                    pend_d  = ev.d;
                    lat_cnt = int'($urandom_range(lat_max, lat_min));
                    if (pend_rx) i_spiRxBusy = 1'b1;
                    else         i_spiTxBusy = 1'b1;
                end
            end
            tx_prev = o_spiTxBegin;
            rx_prev = o_spiRxBegin;
        end
    end

    task automatic tick();
        @(posedge i_clock);
        #2;
    endtask

    task automatic do_restart();
        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
    endtask

    task automatic wait_log(input int target, input int budget, output bit ok);
        ok = (log_q.size() >= target);
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = (log_q.size() >= target);
        end
    endtask

    task automatic wait_status(input int budget, output bit ok);
        ok = o_initDone || o_initError;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = o_initDone || o_initError;
        end
    endtask

    task automatic host_txn(input bit wr, input logic [6:0] a, input logic [7:0] d,
                            output bit got, output bit e, output logic [7:0] rd);
        i_hostWrite   = wr;
        i_hostAddress = a;
        i_hostData    = d;
        i_hostReq     = 1'b1;
        got = 0;
        e   = 0;
        rd  = 8'h00;
        for (int i = 0; i < 600 && !got; i++) begin
            tick();
            if (o_hostAck) begin
                got = 1;
                e   = o_hostError;
                rd  = o_hostRxData;
            end
        end
        i_hostReq = 1'b0;
    endtask

    function automatic void build_exp();
        ev_t x;
        exp_q.delete();
        for (int i = 0; i < 8 && i < TD; i++) begin
            if (t_op[i] == 3) break;
            if (t_op[i] <= 1) begin
                x.rx = (t_op[i] == 1);
                x.a  = 7'(t_a[i]);
                x.d  = 8'(t_d[i]);
                x.t  = 0;
                exp_q.push_back(x);
            end
        end
    endfunction

    function automatic int rx_count(input int base);
        int n = 0;
        for (int i = base; i < log_q.size(); i++) if (log_q[i].rx) n++;
        return n;
    endfunction

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) tick();
        n_vec++;
        if (outs !== 36'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
    endtask

    task automatic test_init_echo();
        int  t0;
        int  base;
        bit  ok;
        mode = 0; lat_min = 1; lat_max = 5;
        base = log_q.size();
        i_reset = 1'b0;
        t0 = cyc;
        wait_status(PU + 500, ok);
        n_vec++;
        if (!ok || o_initDone !== 1'b1 || o_initError !== 1'b0) begin
            n_err++;
            $display("FAIL init_done: done=%b err=%b want 1/0", o_initDone, o_initError);
        end
        build_exp();
        n_vec++;
        if (log_q.size() - base != exp_q.size()) begin
            n_err++;
            $display("FAIL init_count: got %0d want %0d", log_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (base + i >= log_q.size() || log_q[base+i].rx != exp_q[i].rx ||
                log_q[base+i].a !== exp_q[i].a ||
                (!exp_q[i].rx && log_q[base+i].d !== exp_q[i].d)) begin
                n_err++;
                $display("FAIL init_seq[%0d]: want rx=%0b a=%h d=%h", i,
                         exp_q[i].rx, exp_q[i].a, exp_q[i].d);
            end
            if (!exp_q[i].rx) ref_mem[exp_q[i].a] = exp_q[i].d;
        end
        n_vec++;
        if (log_q.size() <= base || log_q[base].t - t0 < PU) begin
            n_err++;
            $display("FAIL powerup_wait: first begin too early or missing (want >= %0d)", PU);
        end
    endtask

    task automatic test_delay();
        int base;
        int g1;
        int g2;
        bit ok;
        mode = 0; lat_min = 3; lat_max = 3;
        base = log_q.size();
        do_restart();
        wait_status(500, ok);
        n_vec++;
        if (!ok || log_q.size() - base != 5) begin
            n_err++;
            $display("FAIL delay_run: got %0d begins want 5", log_q.size() - base);
        end else begin
            g1 = log_q[base+3].t - log_q[base+2].t;
            g2 = log_q[base+4].t - log_q[base+3].t;
            n_vec++;
            if (g1 - g2 != 3 * DU || g1 < 3 * DU) begin
                n_err++;
                $display("FAIL delay_gap: got %0d want %0d", g1 - g2, 3 * DU);
            end
        end
    endtask

    task automatic test_host_random();
        bit         wr;
        bit         got;
        bit         e;
        logic [6:0] a;
        logic [7:0] d;
        logic [7:0] rd;
        ev_t        last;
        mode = 0; lat_min = 1; lat_max = 4;
        for (int k = 0; k < 16; k++) begin
            wr = 1'($urandom_range(1, 0));
            a  = 7'($urandom_range(127, 0));
            d  = 8'($urandom_range(255, 0));
            host_txn(wr, a, d, got, e, rd);
            n_vec++;
            if (!got || e) begin
                n_err++;
                $display("FAIL host_ack[%0d]: got=%0b err=%0b want 1/0", k, got, e);
            end
            last = log_q[log_q.size()-1];
            n_vec++;
            if (last.rx == wr || last.a !== a || (wr && last.d !== d)) begin
                n_err++;
                $display("FAIL host_spi[%0d]: rx=%0b a=%h d=%h want a=%h", k,
                         last.rx, last.a, last.d, a);
            end
            if (wr) begin
                ref_mem[a] = d;
            end else begin
                n_vec++;
                if (rd !== ref_mem[a]) begin
                    n_err++;
                    $display("FAIL host_rd[%0d]: got %h want %h", k, rd, ref_mem[a]);
                end
            end
        end
    endtask

    task automatic test_host_during_init();
        int  base;
        bit  got;
        bit  early;
        logic [7:0] rd;
        mode = 0; lat_min = 1; lat_max = 4;
        dev_mem[7'h15] = 8'hA5;
        ref_mem[7'h15] = 8'hA5;
        base = log_q.size();
        i_hostWrite   = 1'b0;
        i_hostAddress = 7'h15;
        i_hostReq     = 1'b1;
        do_restart();
        n_vec++;
        if (o_initDone !== 1'b0) begin
            n_err++;
            $display("FAIL restart_wins: done=%b want 0", o_initDone);
        end
        got = 0; early = 0; rd = 8'h00;
        for (int i = 0; i < 600 && !got; i++) begin
            tick();
            if (o_hostAck) begin
                got = 1;
                rd  = o_hostRxData;
                if (o_initDone !== 1'b1) early = 1;
            end
        end
        i_hostReq = 1'b0;
        build_exp();
        n_vec++;
        if (!got || early || rd !== 8'hA5) begin
            n_err++;
            $display("FAIL host_init_rd: got=%0b early=%0b data=%h want A5", got, early, rd);
        end
        n_vec++;
        if (log_q.size() - base != exp_q.size() + 1 || !log_q[log_q.size()-1].rx ||
            log_q[log_q.size()-1].a !== 7'h15) begin
            n_err++;
            $display("FAIL host_init_seq: begins=%0d want %0d ending rx@15",
                     log_q.size() - base, exp_q.size() + 1);
        end
    endtask

    task automatic test_verify_fail();
        int  base;
        bit  ok;
        bit  got;
        bit  e;
        logic [6:0] a;
        logic [7:0] d;
        logic [7:0] rd;
        mode = 1; lat_min = 1; lat_max = 4;
        base = log_q.size();
        do_restart();
        wait_status(800, ok);
        n_vec++;
        if (!ok || o_initError !== 1'b1 || o_initDone !== 1'b0) begin
            n_err++;
            $display("FAIL verify_err: err=%b done=%b want 1/0", o_initError, o_initDone);
        end
        n_vec++;
        if (rx_count(base) != MR + 1) begin
            n_err++;
            $display("FAIL verify_retries: got %0d rx begins want %0d", rx_count(base), MR + 1);
        end
        mode = 0;
        a = 7'($urandom_range(127, 32));
        d = 8'($urandom_range(255, 0));
        host_txn(1'b1, a, d, got, e, rd);
        ref_mem[a] = d;
        n_vec++;
        if (!got || e || o_initError !== 1'b1) begin
            n_err++;
            $display("FAIL err_host_wr: got=%0b herr=%0b ierr=%b want 1/0/1", got, e, o_initError);
        end
    endtask

    task automatic test_timeout();
        int  base;
        int  dt;
        bit  ok;
        bit  got;
        bit  e;
        logic [7:0] rd;
        mode = 2;
        base = log_q.size();
        do_restart();
        wait_status(TO + 200, ok);
        dt = (log_q.size() > base) ? cyc - log_q[base].t : -1;
        n_vec++;
        if (!ok || o_initError !== 1'b1 || dt < TO || dt > TO + 2) begin
            n_err++;
            $display("FAIL spi_timeout: err=%b after %0d cycles want %0d", o_initError, dt, TO);
        end
        host_txn(1'b1, 7'h22, 8'h5A, got, e, rd);
        n_vec++;
        if (!got || !e) begin
            n_err++;
            $display("FAIL host_timeout: ack=%0b herr=%0b want 1/1", got, e);
        end
        tick();
        n_vec++;
        if (o_initError !== 1'b1 || o_initDone !== 1'b0 || o_hostError !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_state: ierr=%b done=%b herr=%b want 1/0/0",
                     o_initError, o_initDone, o_hostError);
        end
    endtask

    task automatic test_reset_mid();
        int  base;
        int  t0;
        int  dt;
        bit  ok;
        mode = 0; lat_min = 8; lat_max = 8;
        base = log_q.size();
        do_restart();
        wait_log(base + 1, 50, ok);
        tick();
        tick();
        #1;
        i_reset = 1'b1;
        #1;
        n_vec++;
        if (!ok || outs !== 36'h0) begin
            n_err++;
            $display("FAIL reset_mid: got %h want 0", outs);
        end
        repeat (3) tick();
        i_reset = 1'b0;
        t0 = cyc;
        base = log_q.size();
        wait_log(base + 1, PU + 40, ok);
        dt = ok ? log_q[base].t - t0 : -1;
        n_vec++;
        if (!ok || dt < PU || dt > PU + 10) begin
            n_err++;
            $display("FAIL reset_powerup: first begin after %0d cycles want >= %0d", dt, PU);
        end
        wait_status(600, ok);
        n_vec++;
        if (!ok || o_initDone !== 1'b1) begin
            n_err++;
            $display("FAIL reset_reinit: done=%b want 1", o_initDone);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            logic [7:0] v;
            v = 8'($urandom_range(255, 0));
            dev_mem[i] = v;
            ref_mem[i] = v;
        end
        test_reset();
        test_init_echo();
        test_delay();
        test_host_random();
        test_host_during_init();
        test_verify_fail();
        test_timeout();
        test_reset_mid();
        n_vec++;
        if (viol != 0) begin
            n_err++;
            $display("FAIL spi_protocol: %0d begin violations want 0", viol);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
